rvb_shifter_arb: RTL and testbench

- Shares one rvb_shifter instance between NREQ requesters, e.g. two issue slots or a core plus a co-processor port.
- Arbitrates incoming operations round-robin and drives the shifter's din_* interface.
- Records the grant ID of every accepted operation in an in-order tag FIFO.
- Routes each shifter dout_rd result back to the requester that issued it; the shifter may be pipelined with arbitrary latency.

---
 rtl/rvb_shifter_arb_if.sv | 51 +++++
 rtl/rvb_shifter_arb.sv | 130 +++++++++++++
 tb/tb_rvb_shifter_arb.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvb_shifter_arb_if.sv
// Signal bundle between rvb_shifter_arb, its requesters and the shared rvb_shifter.
// Valid/ready: a transfer completes on a clock edge where valid and ready are both high.
// A producer holds its data stable while valid is high and ready is low.
interface rvb_shifter_arb_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_rs1;
  logic [NREQ*XLEN-1:0] req_rs2;
  logic [NREQ*XLEN-1:0] req_rs3;
  logic [NREQ*7-1:0]    req_op;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [XLEN-1:0]      resp_rd;

  logic                 sh_din_valid;
  logic                 sh_din_ready;
  logic [XLEN-1:0]      sh_rs1;
  logic [XLEN-1:0]      sh_rs2;
  logic [XLEN-1:0]      sh_rs3;
  logic                 sh_insn3;
  logic                 sh_insn13;
  logic                 sh_insn14;
  logic                 sh_insn26;
  logic                 sh_insn27;
  logic                 sh_insn29;
  logic                 sh_insn30;
  logic                 sh_dout_valid;
  logic                 sh_dout_ready;
  logic [XLEN-1:0]      sh_dout_rd;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rs3, req_op, resp_ready,
           sh_din_ready, sh_dout_valid, sh_dout_rd,
    output req_ready, resp_valid, resp_rd,
           sh_din_valid, sh_rs1, sh_rs2, sh_rs3,
           sh_insn3, sh_insn13, sh_insn14, sh_insn26, sh_insn27, sh_insn29, sh_insn30,
           sh_dout_ready
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_rs3, req_op, resp_ready,
           sh_din_ready, sh_dout_valid, sh_dout_rd,
    input  req_ready, resp_valid, resp_rd,
           sh_din_valid, sh_rs1, sh_rs2, sh_rs3,
           sh_insn3, sh_insn13, sh_insn14, sh_insn26, sh_insn27, sh_insn29, sh_insn30,
           sh_dout_ready
  );
endinterface

// File: rtl/rvb_shifter_arb.sv
// Round-robin sharing of one rvb_shifter between NREQ requesters, with an in-order tag FIFO
// routing results back. Define RVB_SHIFTER_ARB_STATS_EN to add grant/stall counters.
module rvb_shifter_arb #(
  parameter int XLEN  = 32,
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               resetn,
  rvb_shifter_arb_if.slave   bus,
`ifdef RVB_SHIFTER_ARB_STATS_EN
  output logic [NREQ*32-1:0] stat_grants,
  output logic [31:0]        stat_stall,
`endif
  output logic               proto_err
);
  localparam int GW = $clog2(NREQ);
  localparam int SW = GW + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [GW-1:0] rr_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [GW-1:0] tag_mem [DEPTH];

  logic          fifo_full;
  logic          fifo_empty;
  logic [GW-1:0] head;
  logic [GW-1:0] grant;
  logic [GW-1:0] cand;
  logic [SW-1:0] sum;
  logic          found;
  logic          any_valid;
  logic          issue;
  logic          ret_hs;
  logic          pop;
  logic [6:0]    op;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = tag_mem[rd_ptr[AW-1:0]];
  assign any_valid  = |bus.req_valid;

  always_comb begin : grant_scan
    grant = rr_ptr;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      cand = sum[GW-1:0];
      if (!found && bus.req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Full blocks issue even when a pop lands in the same cycle: keeps resp_ready off the req_ready path.
  assign issue = resetn & ~fifo_full & any_valid & bus.sh_din_ready;

  always_comb begin : issue_side
    bus.sh_din_valid = resetn & ~fifo_full & any_valid;
    bus.sh_rs1       = bus.req_rs1[0 +: XLEN];
    bus.sh_rs2       = bus.req_rs2[0 +: XLEN];
    bus.sh_rs3       = bus.req_rs3[0 +: XLEN];
    op               = bus.req_op[0 +: 7];
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = issue && (grant == GW'(i));
      if (grant == GW'(i)) begin
        bus.sh_rs1 = bus.req_rs1[i*XLEN +: XLEN];
        bus.sh_rs2 = bus.req_rs2[i*XLEN +: XLEN];
        bus.sh_rs3 = bus.req_rs3[i*XLEN +: XLEN];
        op         = bus.req_op[i*7 +: 7];
      end
    end
    {bus.sh_insn3, bus.sh_insn13, bus.sh_insn14, bus.sh_insn26,
     bus.sh_insn27, bus.sh_insn29, bus.sh_insn30} = op;
  end

  // With no tag outstanding the result is swallowed so a misbehaving shifter cannot wedge.
  always_comb begin : return_side
    bus.resp_rd       = bus.sh_dout_rd;
    bus.sh_dout_ready = resetn & (fifo_empty | bus.resp_ready[head]);
    for (int i = 0; i < NREQ; i++) begin
      bus.resp_valid[i] = resetn & bus.sh_dout_valid & ~fifo_empty & (head == GW'(i));
    end
  end

  assign ret_hs = bus.sh_dout_valid & bus.sh_dout_ready;
  assign pop    = ret_hs & ~fifo_empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (ret_hs && fifo_empty) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (issue) tag_mem[wr_ptr[AW-1:0]] <= grant;
  end

`ifdef RVB_SHIFTER_ARB_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (issue && (grant == GW'(i)))
          stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
      end
      if (any_valid && !issue) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rvb_shifter_arb.sv
// Bench for rvb_shifter_arb: the bench plays both requesters and a variable-latency in-order
// shifter stand-in, and checks every port against an issue-order result queue.
module tb_rvb_shifter_arb;
  localparam int XLEN  = 32;
  localparam int NREQ  = 2;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic proto_err;
  always #5 clock = ~clock;

  rvb_shifter_arb_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();
`ifdef RVB_SHIFTER_ARB_STATS_EN
  logic [NREQ*32-1:0] stat_grants;
  logic [31:0]        stat_stall;
`endif

  rvb_shifter_arb #(.XLEN(XLEN), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .bus        (bus),
`ifdef RVB_SHIFTER_ARB_STATS_EN
    .stat_grants(stat_grants),
    .stat_stall (stat_stall),
`endif
    .proto_err  (proto_err)
  );

  // ---------------- bench state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [XLEN-1:0] op_rs1 [NREQ];
  logic [XLEN-1:0] op_rs2 [NREQ];
  logic [XLEN-1:0] op_rs3 [NREQ];
  logic [6:0]      op_op  [NREQ];
  int              ops_left [NREQ];
  bit              en [NREQ];
  logic [NREQ-1:0] rready;
  bit              din_ready;
  bit              hold_dout;
  int              lat_max;

  // Scoreboard: {issuing requester, expected result} in issue order.
  logic [XLEN:0]   exp_q[$];
  logic [XLEN-1:0] sh_q[$];
  int              sh_t[$];
  int              m_rr;
  bit              m_proto;
  int              st_grants [NREQ];
  int              st_stall;

  int              dut_glog[$];
  int              dut_issue_cnt;
  int              dut_resp_hs [NREQ];
  logic [XLEN-1:0] first_rd0;
  bit              got_first0;
  logic [XLEN-1:0] samp_rs1;

  // Stand-in shifter datapath: SLL plus rs3/op folded in so every operand bit reaches the result.
  function automatic logic [XLEN-1:0] shf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [XLEN-1:0] c, input logic [6:0] o);
    return (a << b[4:0]) ^ c ^ {25'd0, o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_op(input int i);
    op_rs1[i] = $urandom;
    op_rs2[i] = $urandom;
    op_rs3[i] = $urandom;
    op_op[i]  = 7'($urandom_range(0, 127));
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = en[i] && (ops_left[i] > 0);
      bus.req_rs1[i*XLEN +: XLEN]  = op_rs1[i];
      bus.req_rs2[i*XLEN +: XLEN]  = op_rs2[i];
      bus.req_rs3[i*XLEN +: XLEN]  = op_rs3[i];
      bus.req_op[i*7 +: 7]         = op_op[i];
    end
    bus.resp_ready   = rready;
    bus.sh_din_ready = din_ready;
    if (!hold_dout && sh_q.size() > 0 && cyc >= sh_t[0]) begin
      bus.sh_dout_valid = 1'b1;
      bus.sh_dout_rd    = sh_q[0];
    end else begin
      bus.sh_dout_valid = 1'b0;
      bus.sh_dout_rd    = $urandom;
    end
  endtask

  task automatic reset_zero(input string tag);
    chk({tag, "_req_ready"},    bus.req_ready, 0);
    chk({tag, "_sh_din_valid"}, bus.sh_din_valid, 0);
    chk({tag, "_resp_valid"},   bus.resp_valid, 0);
    chk({tag, "_sh_dout_ready"},bus.sh_dout_ready, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    sh_q.delete();
    sh_t.delete();
    m_rr     = 0;
    m_proto  = 0;
    st_stall = 0;
    for (int i = 0; i < NREQ; i++) st_grants[i] = 0;
  endtask

  // One clock: drive, check outputs at negedge against the model, advance the model at posedge.
  task automatic cycle();
    logic [NREQ-1:0] v;
    logic [6:0]      sop;
    logic [XLEN-1:0] samp_res;
    bit any, full, empty, dv, n_issue, n_pop, n_drop, n_stall;
    int g, t, c;
    drive();
    @(negedge clock);
    v = bus.req_valid;
    dv = bus.sh_dout_valid;
    any = |v;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_rr + k) % NREQ;
      if (g < 0 && v[c]) g = c;
    end
    full    = (exp_q.size() == DEPTH);
    empty   = (exp_q.size() == 0);
    n_issue = any && !full && din_ready;
    chk("sh_din_valid", bus.sh_din_valid, any && !full);
    chk("req_ready", bus.req_ready, n_issue ? (1 << g) : 0);
    samp_rs1 = bus.sh_rs1;
    samp_res = '0;
    if (any) begin
      sop = {bus.sh_insn3, bus.sh_insn13, bus.sh_insn14, bus.sh_insn26,
             bus.sh_insn27, bus.sh_insn29, bus.sh_insn30};
      chk("sh_rs1", bus.sh_rs1, op_rs1[g]);
      chk("sh_rs2", bus.sh_rs2, op_rs2[g]);
      chk("sh_rs3", bus.sh_rs3, op_rs3[g]);
      chk("sh_insn", sop, op_op[g]);
      samp_res = shf(bus.sh_rs1, bus.sh_rs2, bus.sh_rs3, sop);
    end
    if (bus.req_ready != 0) begin
      dut_glog.push_back(bus.req_ready[1] ? 1 : 0);
      dut_issue_cnt++;
    end
    t = empty ? 0 : int'(exp_q[0][XLEN]);
    chk("resp_valid", bus.resp_valid, (dv && !empty) ? (1 << t) : 0);
    chk("sh_dout_ready", bus.sh_dout_ready, empty ? 1 : rready[t]);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.resp_valid[i] && rready[i]) begin
        dut_resp_hs[i]++;
        if (i == 0 && !got_first0) begin
          first_rd0  = bus.resp_rd;
          got_first0 = 1;
        end
      end
    end
    n_pop  = dv && !empty && rready[t];
    n_drop = dv && empty;
    if (n_pop) chk("resp_rd", bus.resp_rd, exp_q[0][XLEN-1:0]);
    n_stall = any && !n_issue;
    @(posedge clock);
    #1;
    if (n_pop) begin
      void'(exp_q.pop_front());
      void'(sh_q.pop_front());
      void'(sh_t.pop_front());
    end
    if (n_drop) begin
      m_proto = 1;
      void'(sh_q.pop_front());
      void'(sh_t.pop_front());
    end
    if (n_issue) begin
      exp_q.push_back({g[0], shf(op_rs1[g], op_rs2[g], op_rs3[g], op_op[g])});
      sh_q.push_back(samp_res);
      sh_t.push_back(cyc + $urandom_range(1, lat_max));
      m_rr = (g + 1) % NREQ;
      st_grants[g]++;
      ops_left[g]--;
      new_op(g);
    end
    if (n_stall) st_stall++;
    chk("proto_err", proto_err, m_proto);
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || sh_q.size() > 0 ||
            (en[0] && ops_left[0] > 0) || (en[1] && ops_left[1] > 0)) && n < 400) begin
      cycle();
      n++;
    end
    chk({tag, "_drain_in_budget"}, n < 400, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base, b0, b1;
    logic [XLEN-1:0] r0;
    lat_max = 1; din_ready = 1; hold_dout = 0; rready = '1;
    for (int i = 0; i < NREQ; i++) begin
      en[i] = 1; ops_left[i] = 0; dut_resp_hs[i] = 0; new_op(i);
    end
    clear_model();
    dut_issue_cnt = 0; got_first0 = 0; first_rd0 = '0;
    // Hostile inputs while held in reset.
    bus.req_valid = '1; bus.resp_ready = '1; bus.sh_din_ready = 1'b1;
    bus.sh_dout_valid = 1'b1; bus.sh_dout_rd = $urandom;
    bus.req_rs1 = {$urandom, $urandom}; bus.req_rs2 = '0; bus.req_rs3 = '0; bus.req_op = '0;
    #3;
    reset_zero("por");
    chk("por_proto_err", proto_err, 0);
    @(posedge clock); #1;
    resetn = 1;

    // Fair alternation; first op is SLL 0x1 by 4.
    op_rs1[0] = 32'h1; op_rs2[0] = 32'd4; op_rs3[0] = '0; op_op[0] = '0;
    ops_left = '{4, 4};
    dut_glog.delete();
    drain("fair");
    chk("fair_grant_count", dut_glog.size(), 8);
    for (int k = 0; k < 8 && k < dut_glog.size(); k++) chk($sformatf("fair_grant_%0d", k), dut_glog[k], k % 2);
    chk("fair_first_rd0", first_rd0, 32'h10);

    // Full FIFO: results held back for 10 cycles.
    hold_dout = 1; ops_left = '{6, 6}; base = dut_issue_cnt;
    repeat (10) cycle();
    chk("full_issue_count", dut_issue_cnt - base, 4);
    chk("full_req_ready", bus.req_ready, 0);
    chk("full_din_valid", bus.sh_din_valid, 0);
    hold_dout = 0;
    drain("full");

    // Response backpressure on requester 1 while its tag heads the FIFO.
    rready = 2'b01; ops_left = '{0, 1};
    cycle();
    ops_left[0] = 1; b0 = dut_resp_hs[0]; b1 = dut_resp_hs[1];
    repeat (5) cycle();
    chk("bp_dout_ready", bus.sh_dout_ready, 0);
    chk("bp_no_early_r0", dut_resp_hs[0] - b0, 0);
    rready = 2'b11;
    drain("bp");
    chk("bp_r1_done", dut_resp_hs[1] - b1, 1);
    chk("bp_r0_done", dut_resp_hs[0] - b0, 1);

    // Stall hold with shifter not ready.
    din_ready = 0; ops_left = '{2, 2};
    cycle();
    r0 = samp_rs1;
    repeat (2) begin
      cycle();
      chk("stall_rs1_stable", samp_rs1, r0);
    end
    din_ready = 1;
    drain("stall");

    // Asynchronous reset with 3 operations in flight.
    hold_dout = 1; ops_left = '{3, 0};
    repeat (3) cycle();
    hold_dout = 0; ops_left = '{2, 2};
    drive();
    #2 resetn = 0;
    #1;
    reset_zero("async");
    clear_model();
    en = '{0, 0}; ops_left = '{0, 0};
    drive();
    @(posedge clock); #1;
    reset_zero("async_hold");
    chk("async_proto_err", proto_err, 0);
    resetn = 1;
    en = '{1, 1};
    rready = 2'b00;
    sh_q.push_back(32'h5a5a_0001);
    sh_t.push_back(cyc);
    cycle();
    chk("stray_proto_err", proto_err, 1);
    rready = 2'b11;
    cycle();

    // Randomized traffic.
    lat_max = 3; ops_left = '{1000, 1000};
    repeat (300) begin
      for (int i = 0; i < NREQ; i++) en[i] = ($urandom_range(0, 9) < 7);
      din_ready = ($urandom_range(0, 3) != 0);
      rready    = NREQ'($urandom_range(0, 3));
      hold_dout = ($urandom_range(0, 9) == 0);
      cycle();
    end
    ops_left = '{0, 0}; rready = '1; hold_dout = 0; din_ready = 1;
    drain("random");

`ifdef RVB_SHIFTER_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk($sformatf("stat_grants_%0d", i), stat_grants[i*32 +: 32], st_grants[i]);
    chk("stat_stall", stat_stall, st_stall);
`endif

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
